seg7_scan_driver: RTL and testbench



---
 rtl/seg7_scan_driver_if.sv | 22 ++
 rtl/seg7_scan_driver.sv | 98 +++++++++
 tb/tb_seg7_scan_driver.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/seg7_scan_driver_if.sv
// rtl/seg7_scan_driver_if.sv - segment codes in, multiplexed display bus out
interface seg7_scan_driver_if;
  logic [6:0] seg_d0;
  logic [6:0] seg_d1;
  logic [6:0] seg_d2;
  logic [6:0] seg_d3;
  logic       error;
  logic       hold;
  logic [6:0] seg;
  logic [3:0] an;
  logic       frame_tick;

  modport master (
    output seg_d0, seg_d1, seg_d2, seg_d3, error, hold,
    input  seg, an, frame_tick
  );

  modport slave (
    input  seg_d0, seg_d1, seg_d2, seg_d3, error, hold,
    output seg, an, frame_tick
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - 4-digit time-multiplexed seven-segment scan driver
module seg7_scan_driver #(
  parameter int DIV          = 50000,
  parameter int BLANK        = 500,
  parameter int BLINK_FRAMES = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  seg7_scan_driver_if.slave  bus
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_CNT = CW'(BLANK);
  localparam logic [FW-1:0] FCNT_LAST = FW'(BLINK_FRAMES - 1);

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [FW-1:0] fcnt;
  logic          bph;
  logic          err_sh;
  logic [6:0]    sh [4];

  logic          slot_end;
  logic          frame_end;
  logic          in_blank;
  logic [3:0]    an_nxt;
  logic [6:0]    seg_nxt;

  assign slot_end  = (cnt == CNT_LAST);
  assign frame_end = slot_end && (idx == 2'd3);
  assign in_blank  = (cnt < BLANK_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= 2'd0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Snapshot only at frame end so a digit never changes partway through a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) sh[i] <= 7'h7F;
      err_sh <= 1'b0;
    end else if (frame_end && !bus.hold) begin
      sh[0]  <= bus.seg_d0;
      sh[1]  <= bus.seg_d1;
      sh[2]  <= bus.seg_d2;
      sh[3]  <= bus.seg_d3;
      err_sh <= bus.error;
    end
  end

  // Parked at zero while no error, so a fresh error always opens in the visible phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt <= '0;
      bph  <= 1'b0;
    end else if (!err_sh) begin
      fcnt <= '0;
      bph  <= 1'b0;
    end else if (frame_end) begin
      if (fcnt == FCNT_LAST) begin
        fcnt <= '0;
        bph  <= ~bph;
      end else begin
        fcnt <= fcnt + FW'(1);
      end
    end
  end

  always_comb begin
    an_nxt  = 4'hF;
    seg_nxt = 7'h7F;
    if (!in_blank) begin
      an_nxt = ~(4'b0001 << idx);
      if (!(err_sh && bph)) seg_nxt = sh[idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.an         <= 4'hF;
      bus.seg        <= 7'h7F;
      bus.frame_tick <= 1'b0;
    end else begin
      bus.an         <= an_nxt;
      bus.seg        <= seg_nxt;
      bus.frame_tick <= frame_end;
    end
  end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - randomized self-checking bench for seg7_scan_driver
module tb_seg7_scan_driver;
  localparam int DIV   = 8;
  localparam int BLANK = 2;
  localparam int BF    = 2;
  localparam int FRAME = 4 * DIV;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  // Reference: position within the frame, displayed snapshot, frames elapsed since error capture.
  int         mt;
  int         mage;
  bit         merr;
  logic [6:0] msh [4];

  seg7_scan_driver_if bus ();

  seg7_scan_driver #(.DIV(DIV), .BLANK(BLANK), .BLINK_FRAMES(BF)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h (frame pos %0d)", tag, obs, exp, mt);
    end
  endtask

  task automatic model_reset();
    mt   = 0;
    mage = 0;
    merr = 1'b0;
    for (int i = 0; i < 4; i++) msh[i] = 7'h7F;
  endtask

  task automatic rand_codes();
    bus.seg_d0 = 7'($urandom);
    bus.seg_d1 = 7'($urandom);
    bus.seg_d2 = 7'($urandom);
    bus.seg_d3 = 7'($urandom);
  endtask

  task automatic step();
    int         c;
    int         ix;
    bit         blk;
    logic [3:0] ea;
    logic [6:0] es;
    logic       ef;
    c   = mt % DIV;
    ix  = mt / DIV;
    blk = merr && (((mage / BF) % 2) == 1);
    ea  = (c < BLANK) ? 4'hF : ~(4'b0001 << ix);
    es  = ((c < BLANK) || blk) ? 7'h7F : msh[ix];
    ef  = (mt == FRAME - 1);
    @(posedge clk);
    #1;
    chk("an", bus.an, ea);
    chk("seg", bus.seg, es);
    chk("frame_tick", bus.frame_tick, ef);
    chk("an_one_low", ($countones(~bus.an) <= 1), 1);
    if (ef) begin
      mage = merr ? mage + 1 : 0;
      if (!bus.hold) begin
        msh[0] = bus.seg_d0;
        msh[1] = bus.seg_d1;
        msh[2] = bus.seg_d2;
        msh[3] = bus.seg_d3;
        merr   = bus.error;
      end
    end
    mt = (mt + 1) % FRAME;
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.hold  = 1'b0;
    bus.error = 1'b0;
    bus.seg_d0 = 7'h40;
    bus.seg_d1 = 7'h79;
    bus.seg_d2 = 7'h24;
    bus.seg_d3 = 7'h30;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_an", bus.an, 4'hF);
    chk("reset_seg", bus.seg, 7'h7F);
    chk("reset_frame_tick", bus.frame_tick, 1'b0);
    rst_n = 1'b1;

    // First frame blank, snapshot shows in frame 2, mid-frame change waits for frame 3.
    repeat (FRAME) step();
    repeat (12) step();
    bus.seg_d0 = 7'h19;
    repeat (FRAME - 12) step();
    repeat (FRAME) step();

    // Hold across three frame ends while inputs churn every cycle.
    bus.hold = 1'b1;
    repeat (3 * FRAME) begin
      rand_codes();
      bus.error = 1'($urandom);
      step();
    end
    bus.hold  = 1'b0;
    bus.error = 1'b0;
    rand_codes();
    repeat (2 * FRAME) step();

    // Error blink, then clear, then re-raise to see the phase restart visible.
    bus.error = 1'b1;
    repeat (8 * FRAME) begin
      if ($urandom_range(15) == 0) rand_codes();
      step();
    end
    bus.error = 1'b0;
    repeat (2 * FRAME) step();
    bus.error = 1'b1;
    repeat (3 * FRAME) step();
    bus.error = 1'b0;
    repeat (2 * FRAME) step();

    // Fully random hold/error/codes each cycle; only frame-end values matter.
    repeat (10 * FRAME) begin
      bus.hold  = ($urandom_range(3) == 0);
      bus.error = ($urandom_range(2) == 0);
      rand_codes();
      step();
    end
    bus.hold  = 1'b0;
    bus.error = 1'b0;
    rand_codes();
    repeat (FRAME) step();

    // Reset at cnt=5, idx=2: outputs must drop immediately.
    while (mt != 2 * DIV + 5) step();
    rst_n = 1'b0;
    #1;
    chk("midreset_an", bus.an, 4'hF);
    chk("midreset_seg", bus.seg, 7'h7F);
    chk("midreset_frame_tick", bus.frame_tick, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3 * FRAME) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
